// File: rtl/spectral_peak_tracker.sv
// Streams one FFT frame, tracks the NUM_PEAKS strongest in-range bins above a
// per-frame threshold, then emits them strongest-first over a valid/ready port.
module spectral_peak_tracker #(
  parameter int DATA_W    = 16,
  parameter int FFT_SIZE  = 4096,
  parameter int NUM_PEAKS = 4,
  parameter int MIN_BIN   = 1,
  parameter int MAX_BIN   = 2047,
  localparam int BIN_W    = $clog2(FFT_SIZE),
  localparam int MAG_W    = DATA_W + 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              fft_valid_in,
  input  logic [DATA_W-1:0] fft_data_in,
  input  logic              fft_last_in,
  output logic              fft_ready_out,
  input  logic [MAG_W-1:0]  thresh_in,
  output logic              peak_valid_out,
  input  logic              peak_ready_in,
  output logic [BIN_W-1:0]  peak_bin_out,
  output logic [MAG_W-1:0]  peak_mag_out,
  output logic [2:0]        peak_rank_out,
  output logic              peak_last_out,
  output logic              frame_done_out,
  output logic [3:0]        peak_count_out,
  output logic [1:0]        dbg_state
);

  // Handshake rule for both ports: a transfer happens on a rising clk_in edge
  // where valid and ready are both high; the source holds valid and data
  // stable until that edge and may not withdraw valid before it.

  localparam int H     = DATA_W / 2;
  localparam int IDX_W = (NUM_PEAKS > 1) ? $clog2(NUM_PEAKS) : 1;
  localparam logic [BIN_W-1:0] LO_BIN   = BIN_W'(MIN_BIN);
  localparam logic [BIN_W-1:0] HI_BIN   = BIN_W'(MAX_BIN);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_SIZE - 1);
  localparam logic [3:0]       NP       = 4'(NUM_PEAKS);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             beat;
  logic             frame_end;
  logic             emit_done;
  logic [BIN_W-1:0] bin_cnt;
  logic [MAG_W-1:0] thresh_q;

  logic signed [H-1:0]      s_re, s_im;
  logic signed [DATA_W-1:0] re_ext, im_ext, re_sq, im_sq;
  logic [MAG_W-1:0]         mag_calc;

  logic             s1_valid;
  logic [MAG_W-1:0] s1_mag;
  logic [BIN_W-1:0] s1_bin;
  logic             s1_elig;

  logic [MAG_W-1:0] list_mag [NUM_PEAKS];
  logic [BIN_W-1:0] list_bin [NUM_PEAKS];
  logic             list_vld [NUM_PEAKS];
  logic [3:0]       list_cnt;

  logic             ins_hit;
  logic [2:0]       ins_pos;
  logic [2:0]       next_idx;

  assign dbg_state = state;
  assign beat      = fft_valid_in & fft_ready_out;
  assign frame_end = fft_last_in | (bin_cnt == LAST_BIN);

  // Squares of DATA_W/2-bit signed values always fit DATA_W-1 bits, so the
  // signed DATA_W product is non-negative and the sum fits DATA_W+1 bits.
  assign s_re     = fft_data_in[DATA_W-1:H];
  assign s_im     = fft_data_in[H-1:0];
  assign re_ext   = DATA_W'(s_re);
  assign im_ext   = DATA_W'(s_im);
  assign re_sq    = re_ext * re_ext;
  assign im_sq    = im_ext * im_ext;
  assign mag_calc = MAG_W'($unsigned(re_sq)) + MAG_W'($unsigned(im_sq));

  assign s1_elig = (s1_bin >= LO_BIN) && (s1_bin <= HI_BIN) && (s1_mag >= thresh_q);

  // First rank that is empty or strictly weaker; strict compare keeps the
  // earlier bin ahead on ties.
  always_comb begin
    ins_hit = 1'b0;
    ins_pos = 3'd0;
    for (int r = NUM_PEAKS - 1; r >= 0; r--) begin
      if (!list_vld[r] || (s1_mag > list_mag[r])) begin
        ins_hit = 1'b1;
        ins_pos = 3'(r);
      end
    end
  end

  assign next_idx = peak_rank_out + 3'd1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    fft_ready_out = 1'b0;
    emit_done     = 1'b0;
    case (state)
      COLLECT: begin
        fft_ready_out = 1'b1;
        if (fft_valid_in && frame_end) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = EMIT;
      EMIT: begin
        emit_done = peak_valid_out ? (peak_ready_in && peak_last_out) : (list_cnt == 4'd0);
        if (emit_done) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bin_cnt        <= '0;
      thresh_q       <= '0;
      s1_valid       <= 1'b0;
      s1_mag         <= '0;
      s1_bin         <= '0;
      list_cnt       <= '0;
      peak_valid_out <= 1'b0;
      peak_bin_out   <= '0;
      peak_mag_out   <= '0;
      peak_rank_out  <= '0;
      peak_last_out  <= 1'b0;
      frame_done_out <= 1'b0;
      peak_count_out <= '0;
      for (int r = 0; r < NUM_PEAKS; r++) begin
        list_mag[r] <= '0;
        list_bin[r] <= '0;
        list_vld[r] <= 1'b0;
      end
    end else begin
      s1_valid <= beat;
      if (beat) begin
        s1_mag  <= mag_calc;
        s1_bin  <= bin_cnt;
        bin_cnt <= frame_end ? '0 : bin_cnt + 1'b1;
        if (bin_cnt == '0) thresh_q <= thresh_in;
      end

      if (emit_done) begin
        list_cnt <= '0;
        for (int r = 0; r < NUM_PEAKS; r++) begin
          list_mag[r] <= '0;
          list_bin[r] <= '0;
          list_vld[r] <= 1'b0;
        end
      end else if (s1_valid && s1_elig && ins_hit) begin
        if (list_cnt < NP) list_cnt <= list_cnt + 4'd1;
        if (ins_pos == 3'd0) begin
          list_mag[0] <= s1_mag;
          list_bin[0] <= s1_bin;
          list_vld[0] <= 1'b1;
        end
        for (int r = 1; r < NUM_PEAKS; r++) begin
          if (r == int'(ins_pos)) begin
            list_mag[r] <= s1_mag;
            list_bin[r] <= s1_bin;
            list_vld[r] <= 1'b1;
          end else if (r > int'(ins_pos)) begin
            list_mag[r] <= list_mag[r-1];
            list_bin[r] <= list_bin[r-1];
            list_vld[r] <= list_vld[r-1];
          end
        end
      end

      frame_done_out <= emit_done;

      // Output entry is registered: loaded on the first EMIT cycle, advanced
      // on each handshake, and cleared after the final one.
      if (state == EMIT) begin
        if (!peak_valid_out) begin
          peak_count_out <= list_cnt;
          if (list_cnt != 4'd0) begin
            peak_valid_out <= 1'b1;
            peak_bin_out   <= list_bin[0];
            peak_mag_out   <= list_mag[0];
            peak_rank_out  <= 3'd0;
            peak_last_out  <= (list_cnt == 4'd1);
          end
        end else if (peak_ready_in) begin
          if (peak_last_out) begin
            peak_valid_out <= 1'b0;
            peak_bin_out   <= '0;
            peak_mag_out   <= '0;
            peak_rank_out  <= 3'd0;
            peak_last_out  <= 1'b0;
          end else begin
            peak_bin_out  <= list_bin[next_idx[IDX_W-1:0]];
            peak_mag_out  <= list_mag[next_idx[IDX_W-1:0]];
            peak_rank_out <= next_idx;
            peak_last_out <= (({1'b0, next_idx} + 4'd1) == list_cnt);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spectral_peak_tracker.sv
// Directed bench for spectral_peak_tracker: tones, ordering, ties, range and
// threshold limits, backpressure, counter-terminated frames and reset in EMIT.
module tb_spectral_peak_tracker;

  logic        clk_in;
  logic        rst_in;
  logic        fft_valid_in;
  logic [15:0] fft_data_in;
  logic        fft_last_in;
  logic        fft_ready_out;
  logic [16:0] thresh_in;
  logic        peak_valid_out;
  logic        peak_ready_in;
  logic [11:0] peak_bin_out;
  logic [16:0] peak_mag_out;
  logic [2:0]  peak_rank_out;
  logic        peak_last_out;
  logic        frame_done_out;
  logic [3:0]  peak_count_out;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [15:0] frame_mem [4096];
  logic [11:0] exp_bin_q[$];
  logic [16:0] exp_mag_q[$];

  spectral_peak_tracker dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .fft_valid_in   (fft_valid_in),
    .fft_data_in    (fft_data_in),
    .fft_last_in    (fft_last_in),
    .fft_ready_out  (fft_ready_out),
    .thresh_in      (thresh_in),
    .peak_valid_out (peak_valid_out),
    .peak_ready_in  (peak_ready_in),
    .peak_bin_out   (peak_bin_out),
    .peak_mag_out   (peak_mag_out),
    .peak_rank_out  (peak_rank_out),
    .peak_last_out  (peak_last_out),
    .frame_done_out (frame_done_out),
    .peak_count_out (peak_count_out),
    .dbg_state      (dbg_state)
  );

  // clock / watchdog
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] iq(input int re, input int im);
    return {re[7:0], im[7:0]};
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < 4096; i++) frame_mem[i] = 16'h0000;
  endtask

  // driver: starts and ends on a negedge; returns one cycle after the final beat
  task automatic send_frame(input int len, input bit use_last, input int thr_at,
                            input logic [16:0] thr2);
    int w;
    for (int b = 0; b < len; b++) begin
      fft_valid_in = 1'b1;
      fft_data_in  = frame_mem[b];
      fft_last_in  = use_last && (b == len - 1);
      if (b == thr_at) thresh_in = thr2;
      w = 0;
      while (!fft_ready_out && w < 50) begin
        @(negedge clk_in);
        w++;
      end
      if (w == 50) chk("send_ready_timeout", 32'(fft_ready_out), 32'd1);
      @(posedge clk_in);
      @(negedge clk_in);
    end
    fft_valid_in = 1'b0;
    fft_last_in  = 1'b0;
    fft_data_in  = 16'h0000;
  endtask

  // scoreboard drain: compares each emitted entry with the expected queues
  task automatic get_peaks(input int stall);
    int n;
    int rank;
    int w;
    logic [11:0] eb;
    logic [16:0] em;
    n    = exp_bin_q.size();
    rank = 0;
    while (exp_bin_q.size() > 0) begin
      eb = exp_bin_q.pop_front();
      em = exp_mag_q.pop_front();
      w  = 0;
      while (!peak_valid_out && w < 20) begin
        @(negedge clk_in);
        w++;
      end
      chk("peak_valid", 32'(peak_valid_out), 32'd1);
      chk("peak_bin", 32'(peak_bin_out), 32'(eb));
      chk("peak_mag", 32'(peak_mag_out), 32'(em));
      chk("peak_rank", 32'(peak_rank_out), 32'(rank));
      chk("peak_last", 32'(peak_last_out), 32'(rank == n - 1));
      chk("peak_count", 32'(peak_count_out), 32'(n));
      if (rank == 0 && stall > 0) begin
        peak_ready_in = 1'b0;
        repeat (stall) begin
          @(negedge clk_in);
          chk("stall_valid", 32'(peak_valid_out), 32'd1);
          chk("stall_bin", 32'(peak_bin_out), 32'(eb));
          chk("stall_mag", 32'(peak_mag_out), 32'(em));
          chk("stall_fft_ready", 32'(fft_ready_out), 32'd0);
        end
      end
      peak_ready_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      rank++;
    end
    chk("frame_done_pulse", 32'(frame_done_out), 32'd1);
    chk("valid_after_emit", 32'(peak_valid_out), 32'd0);
    @(negedge clk_in);
    chk("frame_done_clear", 32'(frame_done_out), 32'd0);
    chk("ready_after_emit", 32'(fft_ready_out), 32'd1);
  endtask

  initial begin
    int w;
    rst_in        = 1'b1;
    fft_valid_in  = 1'b0;
    fft_data_in   = 16'h0000;
    fft_last_in   = 1'b0;
    thresh_in     = 17'd0;
    peak_ready_in = 1'b1;
    repeat (3) @(negedge clk_in);

    // reset state
    chk("rst_fft_ready", 32'(fft_ready_out), 32'd1);
    chk("rst_peak_valid", 32'(peak_valid_out), 32'd0);
    chk("rst_frame_done", 32'(frame_done_out), 32'd0);
    chk("rst_count", 32'(peak_count_out), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst_in = 1'b0;

    // single tone, with latency probe: DRAIN at +1, EMIT at +2, valid at +3
    clear_frame();
    frame_mem[64] = iq(60, 0);
    thresh_in = 17'd1;
    send_frame(100, 1'b1, -1, 17'd0);
    chk("t1_c1_valid", 32'(peak_valid_out), 32'd0);
    chk("t1_c1_ready", 32'(fft_ready_out), 32'd0);
    chk("t1_c1_state", 32'(dbg_state), 32'd1);
    @(negedge clk_in);
    chk("t1_c2_valid", 32'(peak_valid_out), 32'd0);
    chk("t1_c2_state", 32'(dbg_state), 32'd2);
    @(negedge clk_in);
    chk("t1_c3_valid", 32'(peak_valid_out), 32'd1);
    exp_bin_q.push_back(12'd64); exp_mag_q.push_back(17'd3600);
    get_peaks(0);

    // four tones, threshold raised mid-frame must not apply to this frame
    clear_frame();
    frame_mem[10] = iq(10, 0);
    frame_mem[20] = iq(20, 0);
    frame_mem[30] = iq(0, -30);
    frame_mem[40] = iq(-40, 0);
    thresh_in = 17'd1;
    send_frame(50, 1'b1, 5, 17'd1000);
    exp_bin_q.push_back(12'd40); exp_mag_q.push_back(17'd1600);
    exp_bin_q.push_back(12'd30); exp_mag_q.push_back(17'd900);
    exp_bin_q.push_back(12'd20); exp_mag_q.push_back(17'd400);
    exp_bin_q.push_back(12'd10); exp_mag_q.push_back(17'd100);
    get_peaks(0);

    // six tones, tie at 900, full-scale corner, 10-cycle backpressure
    clear_frame();
    frame_mem[5]  = iq(30, 0);
    frame_mem[9]  = iq(0, 30);
    frame_mem[12] = iq(50, 0);
    frame_mem[15] = iq(20, 0);
    frame_mem[20] = iq(10, 0);
    frame_mem[25] = iq(-128, -128);
    thresh_in = 17'd50;
    send_frame(30, 1'b1, -1, 17'd0);
    exp_bin_q.push_back(12'd25); exp_mag_q.push_back(17'd32768);
    exp_bin_q.push_back(12'd12); exp_mag_q.push_back(17'd2500);
    exp_bin_q.push_back(12'd5);  exp_mag_q.push_back(17'd900);
    exp_bin_q.push_back(12'd9);  exp_mag_q.push_back(17'd900);
    get_peaks(10);

    // out-of-range strong bins, noise below threshold, frame ended by counter
    clear_frame();
    frame_mem[0]    = iq(100, 0);
    frame_mem[3000] = iq(100, 0);
    for (int i = 100; i < 110; i++) frame_mem[i] = iq(1, 1);
    thresh_in = 17'd50;
    send_frame(4096, 1'b0, -1, 17'd0);
    chk("t4_c1_state", 32'(dbg_state), 32'd1);
    @(negedge clk_in);
    chk("t4_c2_done", 32'(frame_done_out), 32'd0);
    @(negedge clk_in);
    chk("t4_c3_done", 32'(frame_done_out), 32'd1);
    chk("t4_c3_count", 32'(peak_count_out), 32'd0);
    chk("t4_c3_valid", 32'(peak_valid_out), 32'd0);
    chk("t4_c3_ready", 32'(fft_ready_out), 32'd1);
    @(negedge clk_in);
    chk("t4_c4_done", 32'(frame_done_out), 32'd0);

    // reset during EMIT
    clear_frame();
    frame_mem[40] = iq(20, 0);
    thresh_in = 17'd1;
    peak_ready_in = 1'b0;
    send_frame(60, 1'b1, -1, 17'd0);
    w = 0;
    while (!peak_valid_out && w < 20) begin
      @(negedge clk_in);
      w++;
    end
    chk("t5_emit_valid", 32'(peak_valid_out), 32'd1);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("t5_rst_valid", 32'(peak_valid_out), 32'd0);
    chk("t5_rst_bin", 32'(peak_bin_out), 32'd0);
    chk("t5_rst_mag", 32'(peak_mag_out), 32'd0);
    chk("t5_rst_last", 32'(peak_last_out), 32'd0);
    chk("t5_rst_count", 32'(peak_count_out), 32'd0);
    chk("t5_rst_done", 32'(frame_done_out), 32'd0);
    chk("t5_rst_ready", 32'(fft_ready_out), 32'd1);
    chk("t5_rst_state", 32'(dbg_state), 32'd0);
    rst_in = 1'b0;
    peak_ready_in = 1'b1;

    // fresh frame after reset: mag equal to threshold kept, one below dropped
    clear_frame();
    frame_mem[7] = iq(5, 5);
    frame_mem[8] = iq(7, 0);
    thresh_in = 17'd50;
    send_frame(20, 1'b1, -1, 17'd0);
    exp_bin_q.push_back(12'd7); exp_mag_q.push_back(17'd50);
    get_peaks(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
